// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
//
// Multi-channel push-button front end. Every channel is an independent copy of:
//   raw active-low button -> 2-flop synchroniser -> counter debouncer
//   -> press/hold/repeat FSM with registered one-cycle pulse outputs.
//
// Parameters
//   N_CH        number of button channels (>= 1)
//   DEB_CYCLES  consecutive stable cycles needed to accept a new level (>= 2)
//   HOLD_CYCLES cycles of debounced press before long_o fires (>= 1)
//   RPT_CYCLES  auto-repeat period once long_o has fired (>= 1)
//
// Ports
//   clk_i      system clock, rising edge
//   rst_n_i    asynchronous active-low reset
//   btn_n_i    raw buttons, asynchronous, 0 = pressed
//   rpt_en_i   per-channel auto-repeat enable (synchronous)
//   level_o    debounced pressed level, active-high
//   press_o    one-cycle pulse in the first cycle of a new pressed level
//   release_o  one-cycle pulse in the first cycle of a new released level
//   long_o     one-cycle pulse when a hold reaches HOLD_CYCLES
//   rpt_o      pulse on press, then every RPT_CYCLES while held (if enabled)
//   state_o    per-channel FSM state, 2 bits per channel (debug observation)
//
// All outputs are flops; there is no combinational input-to-output path.
// -----------------------------------------------------------------------------
module btn_conditioner #(
  parameter int N_CH        = 4,
  parameter int DEB_CYCLES  = 2_500_000,
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int RPT_CYCLES  = 10_000_000
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [N_CH-1:0]   btn_n_i,
  input  logic [N_CH-1:0]   rpt_en_i,
  output logic [N_CH-1:0]   level_o,
  output logic [N_CH-1:0]   press_o,
  output logic [N_CH-1:0]   release_o,
  output logic [N_CH-1:0]   long_o,
  output logic [N_CH-1:0]   rpt_o,
  output logic [2*N_CH-1:0] state_o
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PRESSED = 2'd1;
  localparam logic [1:0] ST_HELD    = 2'd2;

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int RW = $clog2(RPT_CYCLES + 1);

  // Terminal values: the event happens on the edge where the counter would
  // step from *_LAST to the full count, so the counters never hold it.
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] RPT_LAST  = RW'(RPT_CYCLES - 1);

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    logic          sync1_q;
    logic          sync2_q;
    logic          pressed_s;
    logic [DW-1:0] deb_cnt_q;
    logic          level_q;
    logic          deb_done;
    logic          rise;
    logic          fall;
    logic [1:0]    state_q;
    logic [HW-1:0] hold_cnt_q;
    logic [RW-1:0] rpt_cnt_q;
    logic          press_q;
    logic          release_q;
    logic          long_q;
    logic          rpt_q;

    // Synchroniser resets to 1 so a button held through reset is seen as a
    // fresh press once reset is released.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        sync1_q <= 1'b1;
        sync2_q <= 1'b1;
      end else begin
        sync1_q <= btn_n_i[ch];
        sync2_q <= sync1_q;
      end
    end

    assign pressed_s = ~sync2_q;

    // Toggle decision is shared by the debouncer and the FSM so that the
    // press/release pulses land in the same cycle as the new level.
    assign deb_done = (pressed_s != level_q) && (deb_cnt_q == DEB_LAST);
    assign rise     = deb_done & ~level_q;
    assign fall     = deb_done &  level_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        deb_cnt_q <= '0;
        level_q   <= 1'b0;
      end else if (pressed_s == level_q) begin
        deb_cnt_q <= '0;
      end else if (deb_done) begin
        deb_cnt_q <= '0;
        level_q   <= ~level_q;
      end else begin
        deb_cnt_q <= deb_cnt_q + 1'b1;
      end
    end

    // Release is checked first in every pressed state, so a release landing
    // on a long/repeat edge suppresses that pulse.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        state_q    <= ST_IDLE;
        hold_cnt_q <= '0;
        rpt_cnt_q  <= '0;
        press_q    <= 1'b0;
        release_q  <= 1'b0;
        long_q     <= 1'b0;
        rpt_q      <= 1'b0;
      end else begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        rpt_q     <= 1'b0;
        case (state_q)
          ST_IDLE: begin
            if (rise) begin
              state_q    <= ST_PRESSED;
              press_q    <= 1'b1;
              rpt_q      <= 1'b1;
              hold_cnt_q <= '0;
            end
          end
          ST_PRESSED: begin
            if (fall) begin
              state_q    <= ST_IDLE;
              release_q  <= 1'b1;
              hold_cnt_q <= '0;
              rpt_cnt_q  <= '0;
            end else if (hold_cnt_q == HOLD_LAST) begin
              state_q    <= ST_HELD;
              long_q     <= 1'b1;
              rpt_q      <= rpt_en_i[ch];
              hold_cnt_q <= '0;
              rpt_cnt_q  <= '0;
            end else begin
              hold_cnt_q <= hold_cnt_q + 1'b1;
            end
          end
          ST_HELD: begin
            // The period grid keeps running while repeat is disabled; the
            // enable only gates the pulse itself.
            if (fall) begin
              state_q    <= ST_IDLE;
              release_q  <= 1'b1;
              hold_cnt_q <= '0;
              rpt_cnt_q  <= '0;
            end else if (rpt_cnt_q == RPT_LAST) begin
              rpt_cnt_q <= '0;
              rpt_q     <= rpt_en_i[ch];
            end else begin
              rpt_cnt_q <= rpt_cnt_q + 1'b1;
            end
          end
          default: begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
            rpt_cnt_q  <= '0;
          end
        endcase
      end
    end

    assign level_o[ch]        = level_q;
    assign press_o[ch]        = press_q;
    assign release_o[ch]      = release_q;
    assign long_o[ch]         = long_q;
    assign rpt_o[ch]          = rpt_q;
    assign state_o[2*ch +: 2] = state_q;
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// -----------------------------------------------------------------------------
// Bench for btn_conditioner (N_CH=4, DEB=4, HOLD=20, RPT=8).
// One step = inputs driven at a falling edge, one rising edge, outputs
// sampled at the next falling edge. A button change driven at step s shows
// on level_o (and the matching pulse) at step s+5, i.e. after 6 rising edges.
// -----------------------------------------------------------------------------
module tb_btn_conditioner;
  localparam int N_CH = 4;
  localparam int DEB  = 4;
  localparam int HOLD = 20;
  localparam int RPT  = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N_CH-1:0]   btn_n;
  logic [N_CH-1:0]   rpt_en;
  logic [N_CH-1:0]   level;
  logic [N_CH-1:0]   press;
  logic [N_CH-1:0]   rel;
  logic [N_CH-1:0]   lng;
  logic [N_CH-1:0]   rpt;
  logic [2*N_CH-1:0] st;

  btn_conditioner #(
    .N_CH(N_CH), .DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD), .RPT_CYCLES(RPT)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .btn_n_i(btn_n), .rpt_en_i(rpt_en),
    .level_o(level), .press_o(press), .release_o(rel), .long_o(lng),
    .rpt_o(rpt), .state_o(st)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- vector table ----------------
  typedef struct {
    int         tid;
    logic [3:0] btn;
    logic [3:0] en;
    logic [3:0] lvl;
    logic [3:0] prs;
    logic [3:0] rls;
    logic [3:0] lg;
    logic [3:0] rp;
  } vec_t;

  vec_t        vecs[$];
  logic [19:0] exp_q[$];
  int          n_cmp  = 0;
  int          n_fail = 0;
  int          cur_tid = 0;

  // ---------------- driver tasks ----------------
  task automatic add(input int n, input logic [3:0] btn, input logic [3:0] en,
                     input logic [3:0] lvl, input logic [3:0] prs,
                     input logic [3:0] rls, input logic [3:0] lg,
                     input logic [3:0] rp);
    vec_t v;
    v.tid = cur_tid; v.btn = btn; v.en = en; v.lvl = lvl;
    v.prs = prs; v.rls = rls; v.lg = lg; v.rp = rp;
    repeat (n) vecs.push_back(v);
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input int tid, input int step,
                       input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s test%0d step%0d: got %b, expected %b", name, tid, step, act, exp);
    end
  endtask

  initial begin
    logic [19:0] e;
    int          step;

    rst_n  = 1'b0;
    btn_n  = 4'b0000;
    rpt_en = 4'b0000;

    // Test 1: reset with all buttons held.
    repeat (3) @(negedge clk);
    check("rst_level",   1, 0, {4'b0, level}, 8'h00);
    check("rst_press",   1, 0, {4'b0, press}, 8'h00);
    check("rst_release", 1, 0, {4'b0, rel},   8'h00);
    check("rst_long",    1, 0, {4'b0, lng},   8'h00);
    check("rst_rpt",     1, 0, {4'b0, rpt},   8'h00);
    check("rst_state",   1, 0, st,            8'h00);

    //  n  btn      en       level    press    release  long     rpt
    cur_tid = 1;
    add(5, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(1, 4'b0000, 4'b0000, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b1111);
    add(2, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(5, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 4'b0000);
    add(5, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // Test 2: ch0 glitch of 3 cycles.
    cur_tid = 2;
    add(3,  4'b1110, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(10, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // Test 3: ch1 clean press for 10 cycles, then release.
    cur_tid = 3;
    add(5, 4'b1101, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(1, 4'b1101, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0010);
    add(4, 4'b1101, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(5, 4'b1111, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000);
    add(5, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // Test 4: ch2 held 50 cycles with repeat; press P at step 5.
    cur_tid = 4;
    add(5,  4'b1011, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(1,  4'b1011, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0100); // P
    add(19, 4'b1011, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(1,  4'b1011, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0100); // P+20
    add(7,  4'b1011, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(1,  4'b1011, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100); // P+28
    add(7,  4'b1011, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(1,  4'b1011, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100); // P+36
    add(7,  4'b1011, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(1,  4'b1011, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100); // P+44
    add(5,  4'b1111, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(1,  4'b1111, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000);
    add(10, 4'b1111, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // Test 5: ch3 repeat gated off at P+30, on at P+40; release lands on
    // the P+52 repeat edge, which must be cut off.
    cur_tid = 5;
    add(5,  4'b0111, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(1,  4'b0111, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b1000); // P
    add(19, 4'b0111, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(1,  4'b0111, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 4'b1000); // P+20
    add(7,  4'b0111, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(1,  4'b0111, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b1000); // P+28
    add(1,  4'b0111, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(6,  4'b0111, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000); // P+30..
    add(1,  4'b0111, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000); // P+36 gated
    add(3,  4'b0111, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(4,  4'b0111, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000); // P+40..
    add(1,  4'b0111, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b1000); // P+44
    add(2,  4'b0111, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(5,  4'b1111, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(1,  4'b1111, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000); // P+52
    add(8,  4'b1111, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // Test 6: all channels bounced at once with different patterns.
    cur_tid = 6;
    add(1, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(1, 4'b1100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(2, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(1, 4'b1001, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0010);
    add(1, 4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(1, 4'b1001, 4'b0000, 4'b0110, 4'b0100, 4'b0000, 4'b0000, 4'b0100);
    add(4, 4'b1011, 4'b0000, 4'b0110, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(1, 4'b1111, 4'b0000, 4'b0110, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(1, 4'b1111, 4'b0000, 4'b0100, 4'b0000, 4'b0010, 4'b0000, 4'b0000);
    add(3, 4'b1111, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000);
    add(5, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // Release reset on a falling edge; the next rising edge is step 0.
    rst_n = 1'b1;

    step = 0;
    foreach (vecs[i]) begin
      btn_n  = vecs[i].btn;
      rpt_en = vecs[i].en;
      exp_q.push_back({vecs[i].lvl, vecs[i].prs, vecs[i].rls, vecs[i].lg, vecs[i].rp});
      @(negedge clk);
      e = exp_q.pop_front();
      check("level",   vecs[i].tid, step, {4'b0, level}, {4'b0, e[19:16]});
      check("press",   vecs[i].tid, step, {4'b0, press}, {4'b0, e[15:12]});
      check("release", vecs[i].tid, step, {4'b0, rel},   {4'b0, e[11:8]});
      check("long",    vecs[i].tid, step, {4'b0, lng},   {4'b0, e[7:4]});
      check("rpt",     vecs[i].tid, step, {4'b0, rpt},   {4'b0, e[3:0]});
      if (i + 1 < vecs.size() && vecs[i+1].tid != vecs[i].tid) step = 0;
      else step++;
    end

    // Every channel is back at rest: all FSMs idle.
    check("final_state", 6, step, st, 8'h00);

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Parametrised multi-channel push-button front end. It sits between raw board buttons and user logic, and supersedes the hand-wired single-button synchronizer-plus-debouncer chain. Each channel provides:
- two-flop synchronisation of the active-low input;
- counter-based debouncing;
- press and release edge pulses;
- long-press detection;
- optional auto-repeat.

## Interface
Parameters:
- N_CH, 4: number of independent button channels (≥1).
- DEB_CYCLES, 2_500_000: consecutive stable cycles needed to accept a new level (≥2).
- HOLD_CYCLES, 50_000_000: cycles of debounced press before long-press fires (≥1).
- RPT_CYCLES, 10_000_000: auto-repeat period once long-press has fired (≥1).

Ports:
- clk_i, input, 1: system clock; all logic is on its rising edge.
- rst_n_i, input, 1: asynchronous, active-low reset.
- btn_n_i, input, N_CH: raw button inputs; asynchronous; active-low (0 = pressed).
- rpt_en_i, input, N_CH: per-channel auto-repeat enable; synchronous to clk_i.
- level_o, output, N_CH: debounced pressed level; active-high.
- press_o, output, N_CH: one-cycle pulse on an accepted press.
- release_o, output, N_CH: one-cycle pulse on an accepted release.
- long_o, output, N_CH: one-cycle pulse when the hold reaches HOLD_CYCLES.
- rpt_o, output, N_CH: one pulse per press, then periodic pulses while held (see Operation).

## Operation
Each channel is fully independent and replicated with a generate loop; there is no shared state.
- **Sync:** two flops, reset to 1 (released). Inverted output s = pressed.
- **Debounce:**
  - The counter increments while s ≠ level_o and clears to 0 in any cycle where s = level_o.
  - When the counter would reach DEB_CYCLES, level_o toggles and the counter clears.
  - Counter width is $clog2(DEB_CYCLES+1).
- **FSM states:** IDLE, PRESSED, HELD.
  - IDLE → PRESSED when level_o rises. Fire press_o and rpt_o. Clear the hold counter.
  - PRESSED: the hold counter increments each cycle. When it reaches HOLD_CYCLES, fire long_o and go to HELD. Also fire rpt_o if rpt_en_i=1 in that cycle. Clear the repeat counter.
  - HELD: the repeat counter increments each cycle. When it reaches RPT_CYCLES, clear it and fire rpt_o if rpt_en_i=1 in that cycle.
  - PRESSED/HELD → IDLE when level_o falls. Fire release_o and clear all counters.
- **rpt_en_i changes:** rpt_en_i=0 suppresses rpt_o pulses only. Counting and the HELD state continue, so re-enabling resumes on the existing period grid.
- **Glitches:** any bounce shorter than DEB_CYCLES leaves level_o and all pulses unchanged.
- **Counter overflow:** none possible. The hold counter stops on leaving PRESSED; the repeat counter wraps to 0 at RPT_CYCLES.

## Timing
- **Reset values:** all outputs 0, all counters 0, all FSMs IDLE, sync flops 1.
- **Reset mid-press:** a button still held at reset release is detected as a fresh press. press_o follows after 2+DEB_CYCLES cycles.
- **Input-to-level latency:** a clean edge on btn_n_i sampled at edge t changes level_o at t+2+DEB_CYCLES.
- **Pulse alignment:**
  - press_o and release_o assert in the first cycle of the new level_o value and last exactly 1 cycle.
  - With press at cycle P: long_o at P+HOLD_CYCLES; repeats at P+HOLD_CYCLES+k·RPT_CYCLES, k ≥ 1.
- **Release cut-off:** release in the same cycle a long or repeat would fire suppresses that pulse; release_o has priority.
- **Registered outputs:** all outputs come from flops, with no combinational path from input to output.

## Test plan
Parameters for all tests: N_CH=4, DEB_CYCLES=4, HOLD_CYCLES=20, RPT_CYCLES=8.
1. **Reset:** hold rst_n_i=0 with btn_n_i=0000 → all outputs 0. Release reset → press_o=1111 exactly 6 cycles later.
2. **Glitch reject:** ch0 low for 3 cycles, then high → level_o, press_o and rpt_o stay 0.
3. **Clean press/release:** ch1 low for 10 cycles → press_o[1] and rpt_o[1] at +6, lasting 1 cycle. Release → release_o[1] pulse 6 cycles after btn rises.
4. **Long press with repeat:** ch2, rpt_en_i[2]=1, held 50 cycles → long_o[2] at P+20; rpt_o[2] at P, P+20, P+28, P+36, P+44. Nothing after release.
5. **Repeat gating:** ch3 held, rpt_en_i[3] dropped at P+30 and raised at P+40 → rpt_o[3] at P, P+20, P+28, then next at P+44.
6. **Independence:** all four channels bounced with different patterns at once → each channel's outputs match its single-channel expectation, with no cross-talk.
